// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared constants and types for the memory port arbiter
package mem_port_arbiter_pkg;
  localparam logic [7:0] MMIO_PREFIX = 8'hff;
  typedef enum logic [1:0] {OWN_LD, OWN_ST, OWN_AUX} arb_owner_t;
  typedef enum logic {IDLE, MMIO_HOLD} arb_state_t;
  function automatic logic is_mmio(input logic [29:0] a);
    return a[29:22] == MMIO_PREFIX;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// starve_counter: saturating count of consecutive denied cycles; boosted at LIMIT
module starve_counter #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic granted,
  output logic boosted
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  assign boosted = cnt == W'(LIMIT);
  always_ff @(posedge clk)
    cnt <= (rst || !valid || granted) ? '0 : boosted ? cnt : cnt + 1'b1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the SRAM/CSR port between LD, ST and AUX with starvation boost and MMIO ordering
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ST_STARVE_LIMIT  = 8,
  parameter int AUX_STARVE_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IN_disable,
  input  logic        IN_IO_busy,
  input  logic        IN_LD_valid,
  input  logic        IN_LD_kill,
  input  logic [29:0] IN_LD_addr,
  output logic        OUT_LD_ready,
  input  logic        IN_ST_valid,
  input  logic [29:0] IN_ST_addr,
  input  logic [31:0] IN_ST_data,
  input  logic [3:0]  IN_ST_wm,
  output logic        OUT_ST_ready,
  input  logic        IN_AUX_valid,
  input  logic        IN_AUX_we,
  input  logic [29:0] IN_AUX_addr,
  input  logic [31:0] IN_AUX_data,
  input  logic [3:0]  IN_AUX_wm,
  output logic        OUT_AUX_ready,
  output logic [29:0] OUT_MEM_addr,
  output logic [31:0] OUT_MEM_data,
  output logic [3:0]  OUT_MEM_wm,
  output logic        OUT_MEM_we,
  output logic        OUT_MEM_ce,
  output logic        OUT_CSR_ce,
  input  logic [31:0] IN_MEM_data,
  input  logic [31:0] IN_CSR_data,
  output logic        OUT_LD_rvalid,
  output logic        OUT_AUX_rvalid,
  output logic [31:0] OUT_rdata
);
  arb_state_t state, state_nxt;
  arb_owner_t own, rd_own;
  logic hold_ok, ld_el, st_el, aux_el, st_boost, aux_boost;
  logic g_ld, g_st, g_aux, any, wr, csr, rd_valid, rd_csr;
  assign hold_ok = !IN_IO_busy && state != MMIO_HOLD;
  assign ld_el   = IN_LD_valid && !IN_LD_kill;
  assign st_el   = IN_ST_valid && !IN_disable && (!is_mmio(IN_ST_addr) || hold_ok);
  assign aux_el  = IN_AUX_valid && (!IN_AUX_we || (!IN_disable && (!is_mmio(IN_AUX_addr) || hold_ok)));
  // Boosts only win while the requester is eligible; otherwise fall through the list
  assign g_st  = !rst && st_el && (st_boost || (!(aux_el && aux_boost) && !ld_el));
  assign g_aux = !rst && aux_el && !(st_el && st_boost) && (aux_boost || (!ld_el && !st_el));
  assign g_ld  = !rst && ld_el && !(st_el && st_boost) && !(aux_el && aux_boost);
  assign any   = g_ld || g_st || g_aux;
  assign wr    = g_st || (g_aux && IN_AUX_we);
  assign own   = g_ld ? OWN_LD : g_st ? OWN_ST : OWN_AUX;
  assign OUT_MEM_addr = g_ld ? IN_LD_addr : g_st ? IN_ST_addr : IN_AUX_addr;
  assign OUT_MEM_data = g_st ? IN_ST_data : IN_AUX_data;
  assign OUT_MEM_wm   = g_st ? IN_ST_wm : IN_AUX_wm;
  assign csr          = any && is_mmio(OUT_MEM_addr);
  assign OUT_MEM_we   = !wr;
  assign OUT_MEM_ce   = !(any && !csr);
  assign OUT_CSR_ce   = !csr;
  assign OUT_LD_ready  = g_ld;
  assign OUT_ST_ready  = g_st;
  assign OUT_AUX_ready = g_aux;
  starve_counter #(.LIMIT(ST_STARVE_LIMIT)) u_st (
    .clk(clk), .rst(rst), .valid(IN_ST_valid), .granted(g_st), .boosted(st_boost)
  );
  starve_counter #(.LIMIT(AUX_STARVE_LIMIT)) u_aux (
    .clk(clk), .rst(rst), .valid(IN_AUX_valid), .granted(g_aux), .boosted(aux_boost)
  );
  always_comb state_nxt = (wr && csr) ? MMIO_HOLD : IDLE;
  always_ff @(posedge clk) begin
    state    <= rst ? IDLE : state_nxt;
    rd_valid <= !rst && any && !wr;
    rd_own   <= own;
    rd_csr   <= csr;
  end
  assign OUT_LD_rvalid  = rd_valid && rd_own == OWN_LD;
  assign OUT_AUX_rvalid = rd_valid && rd_own == OWN_AUX;
  assign OUT_rdata      = rd_csr ? IN_CSR_data : IN_MEM_data;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random stimulus checked against a priority-list reference model
module tb_mem_port_arbiter;
  logic clk = 0, rst = 0, dis = 0, io_busy = 0;
  logic ld_valid = 0, ld_kill = 0, st_valid = 0, aux_valid = 0, aux_we = 0;
  logic [29:0] ld_addr = 0, st_addr = 0, aux_addr = 0;
  logic [31:0] st_data = 0, aux_data = 0, mem_data = 0, csr_data = 0;
  logic [3:0] st_wm = 0, aux_wm = 0;
  logic ld_ready, st_ready, aux_ready, mem_we, mem_ce, csr_ce, ld_rvalid, aux_rvalid;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, rdata;
  logic [3:0] mem_wm;
  int n_cmp = 0, n_bad = 0;
  int st_cnt = 0, aux_cnt = 0, pown = 0;
  bit hold = 0, pend = 0, pcsr = 0;
  logic o_ld_r, o_st_r, o_aux_r, o_ld_rv, o_aux_rv, o_mce, o_cce, o_we;
  logic [31:0] o_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst), .IN_disable(dis), .IN_IO_busy(io_busy),
    .IN_LD_valid(ld_valid), .IN_LD_kill(ld_kill), .IN_LD_addr(ld_addr), .OUT_LD_ready(ld_ready),
    .IN_ST_valid(st_valid), .IN_ST_addr(st_addr), .IN_ST_data(st_data), .IN_ST_wm(st_wm),
    .OUT_ST_ready(st_ready),
    .IN_AUX_valid(aux_valid), .IN_AUX_we(aux_we), .IN_AUX_addr(aux_addr), .IN_AUX_data(aux_data),
    .IN_AUX_wm(aux_wm), .OUT_AUX_ready(aux_ready),
    .OUT_MEM_addr(mem_addr), .OUT_MEM_data(mem_wdata), .OUT_MEM_wm(mem_wm), .OUT_MEM_we(mem_we),
    .OUT_MEM_ce(mem_ce), .OUT_CSR_ce(csr_ce), .IN_MEM_data(mem_data), .IN_CSR_data(csr_data),
    .OUT_LD_rvalid(ld_rvalid), .OUT_AUX_rvalid(aux_rvalid), .OUT_rdata(rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    {rst, dis, io_busy, ld_valid, ld_kill, st_valid, aux_valid, aux_we} = '0;
  endtask

  // One clock: check combinational grant/port and registered response, then advance the model
  task automatic cycle();
    int g;
    bit ok, ld_e, st_e, aux_e, wr, csr;
    logic [29:0] a;
    #3;
    ok    = !io_busy && !hold;
    ld_e  = ld_valid && !ld_kill;
    st_e  = st_valid && !dis && (st_addr[29:22] != 8'hff || ok);
    aux_e = aux_valid && (!aux_we || !dis) && (!aux_we || aux_addr[29:22] != 8'hff || ok);
    if (rst) g = 0;
    else if (st_e && st_cnt == 8) g = 2;
    else if (aux_e && aux_cnt == 16) g = 3;
    else if (ld_e) g = 1;
    else if (st_e) g = 2;
    else if (aux_e) g = 3;
    else g = 0;
    a   = g == 1 ? ld_addr : g == 2 ? st_addr : aux_addr;
    wr  = g == 2 || (g == 3 && aux_we);
    csr = g != 0 && a[29:22] == 8'hff;
    {o_ld_r, o_st_r, o_aux_r, o_ld_rv, o_aux_rv} = {ld_ready, st_ready, aux_ready, ld_rvalid, aux_rvalid};
    {o_mce, o_cce, o_we, o_rdata} = {mem_ce, csr_ce, mem_we, rdata};
    chk("ld_ready", ld_ready, g == 1);
    chk("st_ready", st_ready, g == 2);
    chk("aux_ready", aux_ready, g == 3);
    chk("mem_ce", mem_ce, !(g != 0 && !csr));
    chk("csr_ce", csr_ce, !csr);
    chk("mem_we", mem_we, !wr);
    if (g != 0) chk("mem_addr", mem_addr, a);
    if (wr) begin
      chk("mem_data", mem_wdata, g == 2 ? st_data : aux_data);
      chk("mem_wm", mem_wm, g == 2 ? st_wm : aux_wm);
    end
    chk("ld_rvalid", ld_rvalid, pend && pown == 1);
    chk("aux_rvalid", aux_rvalid, pend && pown == 3);
    if (pend) chk("rdata", rdata, pcsr ? csr_data : mem_data);
    @(posedge clk);
    if (rst) begin
      st_cnt = 0; aux_cnt = 0; hold = 0; pend = 0;
    end else begin
      st_cnt  = (!st_valid || g == 2) ? 0 : (st_cnt < 8 ? st_cnt + 1 : 8);
      aux_cnt = (!aux_valid || g == 3) ? 0 : (aux_cnt < 16 ? aux_cnt + 1 : 16);
      hold = wr && csr;
      pend = g != 0 && !wr;
      pown = g;
      pcsr = csr;
    end
    #1;
  endtask

  function automatic logic [29:0] rnd_addr();
    logic [29:0] r;
    r = 30'($urandom);
    if ($urandom_range(0, 3) == 0) r[29:22] = 8'hff;
    return r;
  endfunction

  initial begin
    @(posedge clk); #1;
    rst = 1; ld_valid = 1; st_valid = 1;
    cycle();
    chk("reset_ld_ready", o_ld_r, 0);
    chk("reset_mem_ce", o_mce, 1);
    idle_in();
    cycle();
    chk("post_reset_rvalid", o_ld_rv, 0);
    // All three valid, non-MMIO: LD keeps winning
    ld_valid = 1; st_valid = 1; aux_valid = 1; aux_we = 0;
    ld_addr = 30'h100; st_addr = 30'h200; aux_addr = 30'h300; st_data = 32'h1234_5678; st_wm = 4'hf;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("tri_ld", o_ld_r, 1);
      chk("tri_st", o_st_r, 0);
    end
    idle_in();
    cycle();
    // LD continuous, ST from cycle 0: ST boosted in cycle 8
    ld_valid = 1; st_valid = 1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("boost_st", o_st_r, i == 8);
      chk("boost_ld", o_ld_r, i != 8);
    end
    idle_in();
    cycle();
    // Back-to-back MMIO writes separated by one hold cycle
    st_valid = 1; st_addr = 30'h3FC00000; st_data = 32'hA5A5_0001; st_wm = 4'h3;
    cycle();
    chk("mmio0_ready", o_st_r, 1);
    chk("mmio0_csr_ce", o_cce, 0);
    chk("mmio0_we", o_we, 0);
    st_addr = 30'h3FC00001; st_data = 32'hA5A5_0002;
    cycle();
    chk("mmio_hold_ready", o_st_r, 0);
    chk("mmio_hold_csr_ce", o_cce, 1);
    cycle();
    chk("mmio1_ready", o_st_r, 1);
    chk("mmio1_csr_ce", o_cce, 0);
    idle_in();
    cycle();
    // IO busy holds the MMIO store while an AUX read proceeds
    io_busy = 1; st_valid = 1; st_addr = 30'h3FC00008; aux_valid = 1; aux_we = 0; aux_addr = 30'h10;
    cycle();
    chk("busy_aux", o_aux_r, 1);
    chk("busy_st", o_st_r, 0);
    aux_valid = 0;
    cycle();
    chk("busy_st_held", o_st_r, 0);
    chk("busy_aux_rvalid", o_aux_rv, 1);
    io_busy = 0;
    cycle();
    chk("unbusy_st", o_st_r, 1);
    idle_in();
    cycle();
    // CSR load read data
    ld_valid = 1; ld_addr = 30'h3FC00004;
    cycle();
    chk("csr_ld_ready", o_ld_r, 1);
    chk("csr_ld_ce", o_cce, 0);
    ld_valid = 0; csr_data = 32'hDEADBEEF; mem_data = 32'h0BAD_F00D;
    cycle();
    chk("csr_ld_rvalid", o_ld_rv, 1);
    chk("csr_ld_rdata", o_rdata, 32'hDEADBEEF);
    // Reset during an AUX read grant with ST starving
    ld_valid = 1; ld_kill = 1; dis = 1; st_valid = 1; st_addr = 30'h40;
    aux_valid = 1; aux_we = 0; aux_addr = 30'h20;
    cycle();
    chk("kill_aux", o_aux_r, 1);
    cycle();
    rst = 1;
    cycle();
    chk("rst_aux_ready", o_aux_r, 0);
    idle_in();
    cycle();
    chk("rst_aux_rvalid", o_aux_rv, 0);
    chk("rst_mem_ce", o_mce, 1);
    chk("rst_csr_ce", o_cce, 1);
    chk("rst_we", o_we, 1);
    ld_valid = 1; st_valid = 1; st_addr = 30'h44;
    for (int i = 0; i < 9; i++) begin
      cycle();
      chk("rst_cnt_cleared", o_st_r, i == 8);
    end
    // Random traffic; LD usually valid so starvation boosts get exercised
    for (int i = 0; i < 1500; i++) begin
      rst = $urandom_range(0, 59) == 0;
      dis = $urandom_range(0, 9) == 0;
      io_busy = $urandom_range(0, 3) == 0;
      ld_valid = $urandom_range(0, 9) < 8;
      ld_kill = $urandom_range(0, 7) == 0;
      st_valid = $urandom_range(0, 9) < 7;
      aux_valid = $urandom_range(0, 9) < 7;
      aux_we = $urandom_range(0, 1) == 1;
      ld_addr = rnd_addr(); st_addr = rnd_addr(); aux_addr = rnd_addr();
      st_data = $urandom; aux_data = $urandom; mem_data = $urandom; csr_data = $urandom;
      st_wm = 4'($urandom); aux_wm = 4'($urandom);
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
